// File: rtl/dekatron_step_sequencer.sv
// -----------------------------------------------------------------------------
// dekatron_step_sequencer
//
// Sequences increment, decrement and parallel-load operations on a chain of
// DIGITS cascaded dekatron decades. The sequencer steps one decade, waits a
// cycle for the tube to settle, then inspects that decade's one-hot outputs.
// If it wrapped (9->0 on increment, 0->9 on decrement), the sequencer ripples
// the step into the next decade. A load steps every decade at once, with Set
// selecting the load inputs.
//
// Optional feature: define DEK_OVERFLOW_EN to report carry/borrow out of the
// most significant decade on Overflow, qualified by Done. When the macro is
// undefined, Overflow is tied to 0 and no overflow register is built.
//
// Ports
//   Clk       in   system clock, rising edge
//   Rst_n     in   asynchronous active-low reset
//   Request   in   operation request, sampled only while Ready=1
//   Dec       in   1 = decrement, 0 = increment (latched with Request)
//   Load      in   parallel load, overrides Dec (latched with Request)
//   LoadIn    in   one-hot load value, 10 bits per decade (latched)
//   DigitIn   in   one-hot outputs of the dekatron chain, 10 bits per decade
//   Step      out  per-decade step strobes (registered)
//   Reverse   out  direction to all decades (latched Dec)
//   Set       out  load select to all decades
//   SetData   out  latched LoadIn, driven to the decade load inputs
//   Ready     out  idle and able to accept a request
//   Done      out  one-cycle completion pulse
//   Overflow  out  carry/borrow out of decade DIGITS-1, valid with Done
// -----------------------------------------------------------------------------
module dekatron_step_sequencer #(
    parameter int DIGITS = 3
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Request,
    input  logic                   Dec,
    input  logic                   Load,
    input  logic [DIGITS*10-1:0]   LoadIn,
    input  logic [DIGITS*10-1:0]   DigitIn,
    output logic [DIGITS-1:0]      Step,
    output logic                   Reverse,
    output logic                   Set,
    output logic [DIGITS*10-1:0]   SetData,
    output logic                   Ready,
    output logic                   Done,
    output logic                   Overflow
);

    localparam int            IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          idx_d;
    logic [DIGITS-1:0]      step_q;
    logic                   set_q;
    logic                   dec_q;
    logic                   load_q;
    logic                   ready_q;
    logic                   done_q;
    logic [DIGITS*10-1:0]   set_data_q;
    logic [9:0]             cur_decade;
    logic                   wrap;
    logic                   ripple;

    function automatic logic [DIGITS-1:0] decade_sel(input logic [IW-1:0] i);
        decade_sel    = '0;
        decade_sel[i] = 1'b1;
    endfunction

    // A decade that is not exactly one-hot never compares equal to either
    // wrap pattern, so a glitching tube is treated as "no carry".
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        cur_decade = DigitIn[int'(idx_q) * 10 +: 10];
        wrap       = dec_q ? (cur_decade == 10'b10_0000_0000)
                           : (cur_decade == 10'b00_0000_0001);
        ripple     = wrap && !load_q && (idx_q != LAST_IDX);
        idx_d      = idx_q + IW'(1);
    end

    // Outputs are registered alongside the state, so each strobe is high
    // exactly during the state it belongs to.
    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            step_q     <= '0;
            set_q      <= 1'b0;
            dec_q      <= 1'b0;
            load_q     <= 1'b0;
            set_data_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            step_q <= '0;
            set_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Request) begin
                        dec_q      <= Dec;
                        load_q     <= Load;
                        set_data_q <= LoadIn;
                        idx_q      <= '0;
                        step_q     <= Load ? '1 : decade_sel(IW'(0));
                        set_q      <= Load;
                        ready_q    <= 1'b0;
                        state_q    <= S_STEP;
                    end else begin
                        ready_q    <= 1'b1;
                    end
                end
                S_STEP:   state_q <= S_SETTLE;
                S_SETTLE: state_q <= S_CHECK;
                S_CHECK: begin
                    if (ripple) begin
                        idx_q   <= idx_d;
                        step_q  <= decade_sel(idx_d);
                        state_q <= S_STEP;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DEK_OVERFLOW_EN
    // Wrap of the top decade during a counting CHECK ends the operation
    // with an overflow; the flag is raised on the same edge as Done.
    logic top_wrap;
    logic overflow_q;

    assign top_wrap = wrap && !load_q && (idx_q == LAST_IDX);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= (state_q == S_CHECK) && top_wrap;
        end
    end

    assign Overflow = overflow_q;
`else
    assign Overflow = 1'b0;
`endif

    assign Step    = step_q;
    assign Reverse = dec_q;
    assign Set     = set_q;
    assign SetData = set_data_q;
    assign Ready   = ready_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_dekatron_step_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dekatron_step_sequencer
//
// Self-checking bench for dekatron_step_sequencer with DIGITS=3. The bench
// includes a behavioural model of three dekatron tubes that reacts to Step,
// Set and Reverse. Expected results come from decimal arithmetic on the
// counter value: the final value, how many decades step, the latency, and
// whether the operation wraps past the top decade. The bench runs a directed
// table, randomized operations, and a hand-written mid-operation reset.
// -----------------------------------------------------------------------------
module tb_dekatron_step_sequencer;

    localparam int DIGITS = 3;
    localparam int MAXV   = 1000;
`ifdef DEK_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic                 Clk     = 1'b0;
    logic                 Rst_n   = 1'b1;
    logic                 Request = 1'b0;
    logic                 Dec     = 1'b0;
    logic                 Load    = 1'b0;
    logic [DIGITS*10-1:0] LoadIn  = '0;
    logic [DIGITS*10-1:0] DigitIn;
    logic [DIGITS-1:0]    Step;
    logic                 Reverse;
    logic                 Set;
    logic [DIGITS*10-1:0] SetData;
    logic                 Ready;
    logic                 Done;
    logic                 Overflow;

    int checks = 0;
    int errors = 0;

    int chain [DIGITS];
    bit preset_en  = 1'b0;
    int preset_val = 0;
    bit corrupt    = 1'b0;

    dekatron_step_sequencer #(.DIGITS(DIGITS)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Request  (Request),
        .Dec      (Dec),
        .Load     (Load),
        .LoadIn   (LoadIn),
        .DigitIn  (DigitIn),
        .Step     (Step),
        .Reverse  (Reverse),
        .Set      (Set),
        .SetData  (SetData),
        .Ready    (Ready),
        .Done     (Done),
        .Overflow (Overflow)
    );

    always #5 Clk = ~Clk;

    function automatic int oh2int(input logic [9:0] v);
        oh2int = 0;
        for (int b = 0; b < 10; b++) if (v[b]) oh2int = b;
    endfunction

    function automatic logic [DIGITS*10-1:0] enc(input int v);
        int d;
        enc = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = (v / (10 ** i)) % 10;
            enc[i*10 +: 10] = 10'b1 << d;
        end
    endfunction

    function automatic int chain_val();
        chain_val = 0;
        for (int i = DIGITS - 1; i >= 0; i--) chain_val = chain_val * 10 + chain[i];
    endfunction

    // Dekatron tubes: each decade advances or retreats one place per Step,
    // or jumps to its load input when Set accompanies Step.
    always @(posedge Clk) begin
        for (int i = 0; i < DIGITS; i++) begin
            if (preset_en)
                chain[i] <= (preset_val / (10 ** i)) % 10;
            else if (Step[i] && Set)
                chain[i] <= oh2int(SetData[i*10 +: 10]);
            else if (Step[i])
                chain[i] <= Reverse ? (chain[i] + 9) % 10 : (chain[i] + 1) % 10;
        end
    end

    // The corrupt flag adds a stray glow on decade 0, position 9.
    always_comb begin
        DigitIn = '0;
        for (int i = 0; i < DIGITS; i++) DigitIn[i*10 +: 10] = 10'b1 << chain[i];
        if (corrupt) DigitIn[9] = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model in decimal terms: the final counter value, how many
    // decades step (one plus the run of trailing 9s or 0s, capped at DIGITS),
    // and whether the value wraps past the top decade.
    task automatic ref_model(input int start, input bit dec, input bit load, input int lv,
                             output int fin, output int n, output bit wraps);
        int v;
        if (load) begin
            fin = lv; n = 1; wraps = 1'b0;
        end else begin
            fin   = dec ? (start + MAXV - 1) % MAXV : (start + 1) % MAXV;
            wraps = dec ? (start == 0) : (start == MAXV - 1);
            n = 1;
            v = start;
            while (n < DIGITS && (v % 10) == (dec ? 0 : 9)) begin
                n++;
                v = v / 10;
            end
        end
    endtask

    task automatic run_op(input string tag, input int start, input bit dec, input bit load,
                          input int lv, input bit busy_req, input bit corr,
                          input int exp_fin, input int exp_n, input bit exp_wrap);
        int               cyc;
        int               npulse;
        int               exp_lat;
        bit               got_done;
        bit               ready_bad;
        bit               pulse_bad;
        bit               idle_bad;
        bit               ovf_seen;
        logic [DIGITS-1:0] exp_bits;

        @(negedge Clk);
        preset_en  = 1'b1;
        preset_val = start;
        corrupt    = corr;
        @(negedge Clk);
        preset_en = 1'b0;
        check({tag, " ready_before"}, int'(Ready), 1);
        Request = 1'b1;
        Dec     = dec;
        Load    = load;
        LoadIn  = enc(lv);
        @(posedge Clk);
        #1;
        // Scramble the request-side inputs to show they were latched.
        Request = 1'b0;
        Dec     = 1'($urandom);
        Load    = 1'($urandom);
        LoadIn  = (DIGITS*10)'($urandom);

        cyc = 0; npulse = 0; got_done = 0; ready_bad = 0; pulse_bad = 0; ovf_seen = 0;
        exp_lat = load ? 4 : 4 + 3 * (exp_n - 1);
        while (!got_done && cyc < 40) begin
            @(negedge Clk);
            cyc++;
            if (busy_req) Request = (cyc == 2);
            if (Ready) ready_bad = 1'b1;
            if (Step != '0) begin
                exp_bits = load ? '1 : DIGITS'(1 << npulse);
                if (Step !== exp_bits || Set !== load || Reverse !== dec || cyc != 1 + 3 * npulse)
                    pulse_bad = 1'b1;
                npulse++;
            end else if (Set) begin
                pulse_bad = 1'b1;
            end
            if (Done) begin
                got_done = 1'b1;
                ovf_seen = Overflow;
            end else if (Overflow) begin
                pulse_bad = 1'b1;
            end
        end
        Request = 1'b0;

        check({tag, " done_seen"}, int'(got_done), 1);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " step_pulses"}, npulse, exp_n);
        check({tag, " pulse_shape"}, int'(pulse_bad), 0);
        check({tag, " busy_ready"}, int'(ready_bad), 0);
        check({tag, " overflow"}, int'(ovf_seen), int'(exp_wrap & OVF_EN));

        idle_bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (!Ready || Done || Step != '0 || Set || Overflow) idle_bad = 1'b1;
        end
        check({tag, " idle_after"}, int'(idle_bad), 0);
        check({tag, " chain"}, chain_val(), exp_fin);
    endtask

    typedef struct {
        string tag;
        int    start;
        bit    dec;
        bit    load;
        int    lv;
        bit    busy;
        bit    corr;
        int    fin;
        int    n;
        bit    wrap;
    } vec_t;

    vec_t vecs [9];
    int   edge_vals [8] = '{0, 9, 10, 90, 99, 100, 900, 999};

    initial begin : main
        int  start, lv, fin, n;
        bit  dec, load, wraps;
        bit  stray;

        vecs[0] = '{"inc000",    0,   0, 0, 0,   0, 0, 1,   1, 0};
        vecs[1] = '{"inc019",    19,  0, 0, 0,   0, 0, 20,  2, 0};
        vecs[2] = '{"inc999",    999, 0, 0, 0,   0, 0, 0,   3, 1};
        vecs[3] = '{"dec100",    100, 1, 0, 0,   0, 0, 99,  3, 0};
        vecs[4] = '{"load537",   812, 0, 1, 537, 1, 0, 537, 1, 0};
        vecs[5] = '{"dec000",    0,   1, 0, 0,   0, 0, 999, 3, 1};
        vecs[6] = '{"dec123",    123, 1, 0, 0,   0, 0, 122, 1, 0};
        vecs[7] = '{"inc099",    99,  0, 0, 0,   0, 0, 100, 3, 0};
        vecs[8] = '{"nonhot009", 9,   0, 0, 0,   0, 1, 0,   1, 0};

        // Reset state
        #1 Rst_n = 1'b0;
        #2;
        check("reset ready", int'(Ready), 1);
        check("reset step", int'(Step), 0);
        check("reset set", int'(Set), 0);
        check("reset done", int'(Done), 0);
        check("reset reverse", int'(Reverse), 0);
        check("reset setdata", int'(SetData != '0), 0);
        check("reset overflow", int'(Overflow), 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;

        // Directed table
        foreach (vecs[i])
            run_op(vecs[i].tag, vecs[i].start, vecs[i].dec, vecs[i].load, vecs[i].lv,
                   vecs[i].busy, vecs[i].corr, vecs[i].fin, vecs[i].n, vecs[i].wrap);

        // Randomized operations against the reference model
        for (int k = 0; k < 40; k++) begin
            start = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 7)]
                                                 : int'($urandom_range(0, MAXV - 1));
            load  = ($urandom_range(0, 7) == 0);
            dec   = load ? 1'b0 : 1'($urandom);
            lv    = int'($urandom_range(0, MAXV - 1));
            ref_model(start, dec, load, lv, fin, n, wraps);
            run_op($sformatf("rand%0d", k), start, dec, load, lv,
                   1'($urandom), 1'b0, fin, n, wraps);
        end

        // Reset during SETTLE of an increment of 099: the carry must not ripple.
        @(negedge Clk);
        preset_en  = 1'b1;
        preset_val = 99;
        corrupt    = 1'b0;
        @(negedge Clk);
        preset_en = 1'b0;
        Request   = 1'b1;
        Dec       = 1'b0;
        Load      = 1'b0;
        LoadIn    = enc(246);
        @(posedge Clk);
        #1 Request = 1'b0;
        @(negedge Clk);
        check("rst_mid step0", int'(Step), 1);
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("rst_mid step", int'(Step), 0);
        check("rst_mid set", int'(Set), 0);
        check("rst_mid done", int'(Done), 0);
        check("rst_mid ready", int'(Ready), 1);
        check("rst_mid setdata", int'(SetData != '0), 0);
        check("rst_mid overflow", int'(Overflow), 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Step != '0 || Done || !Ready) stray = 1'b1;
        end
        check("rst_mid no_resume", int'(stray), 0);
        check("rst_mid chain", chain_val(), 90);

        // Normal operation after the abandoned one
        run_op("post_rst_inc090", 90, 0, 0, 0, 0, 0, 91, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
